// File: rtl/tt_um_restador_serie_if.sv
// Pin bundle of the TinyTapeout tile frame used by the serial subtractor.
// The DUT side uses the slave modport; the frame/harness side uses master.
interface tt_um_restador_serie_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (
    output ena,
    output ui_in,
    output uio_in,
    input  uo_out,
    input  uio_out,
    input  uio_oe
  );

  modport slave (
    input  ena,
    input  ui_in,
    input  uio_in,
    output uo_out,
    output uio_out,
    output uio_oe
  );
endinterface

// File: rtl/tt_um_restador_serie.sv
// Bit-serial 4-bit subtractor tile: captures A, B and borrow-in, then
// computes A - B - bin LSB first through one full-subtractor cell and a
// borrow flip-flop, sequenced by an IDLE/SHIFT/DONE state machine.
module tt_um_restador_serie (
  input  logic                         clk,
  input  logic                         rst_n,
  tt_um_restador_serie_if.slave        tile_io
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] rega_q, rega_d;
  logic [3:0] regb_q, regb_d;
  logic [3:0] res_q, res_d;
  logic       brw_q, brw_d;
  logic       sdo_q, sdo_d;
  logic [1:0] cnt_q, cnt_d;

  logic       start_s;
  logic       bin_s;
  logic [1:0] fs_s;
  logic       unused_s;

  // One full-subtractor cell: returns {borrow_out, difference}.
  function automatic logic [1:0] full_sub(input logic a, input logic b, input logic br);
    logic d;
    logic nb;
    d  = a ^ b ^ br;
    nb = (~a & b) | (~(a ^ b) & br);
    return {nb, d};
  endfunction

  assign start_s = tile_io.uio_in[0];
  assign bin_s   = tile_io.uio_in[1];

  // ena and the spare uio inputs have no function in this tile.
  assign unused_s = &{1'b0, tile_io.ena, tile_io.uio_in[7:2]};

  // State and datapath registers; reset aborts any operation at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rega_q  <= 4'd0;
      regb_q  <= 4'd0;
      res_q   <= 4'd0;
      brw_q   <= 1'b0;
      sdo_q   <= 1'b0;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      rega_q  <= rega_d;
      regb_q  <= regb_d;
      res_q   <= res_d;
      brw_q   <= brw_d;
      sdo_q   <= sdo_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and datapath update: capture in IDLE, one bit per SHIFT edge,
  // DONE holds until start is released so a held start cannot retrigger.
  always_comb begin
    state_d = state_q;
    rega_d  = rega_q;
    regb_d  = regb_q;
    res_d   = res_q;
    brw_d   = brw_q;
    sdo_d   = sdo_q;
    cnt_d   = cnt_q;
    fs_s    = full_sub(rega_q[0], regb_q[0], brw_q);
    case (state_q)
      IDLE: begin
        if (start_s) begin
          rega_d  = tile_io.ui_in[3:0];
          regb_d  = tile_io.ui_in[7:4];
          brw_d   = bin_s;
          cnt_d   = 2'd0;
          res_d   = 4'd0;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        res_d  = {fs_s[0], res_q[3:1]};
        rega_d = {1'b0, rega_q[3:1]};
        regb_d = {1'b0, regb_q[3:1]};
        brw_d  = fs_s[1];
        sdo_d  = fs_s[0];
        cnt_d  = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          state_d = DONE;
        end else begin
          state_d = SHIFT;
        end
      end
      DONE: begin
        if (!start_s) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs come straight from registers or decoded registered state.
  assign tile_io.uo_out  = {sdo_q, (state_q == DONE), (state_q == SHIFT), brw_q, res_q};
  assign tile_io.uio_out = 8'h00;
  assign tile_io.uio_oe  = 8'h00;

endmodule

// File: tb/tb_tt_um_restador_serie.sv
// Self-checking bench for the serial subtractor tile. Expected values come
// from plain integer arithmetic on the operands.
module tb_tt_um_restador_serie;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  tt_um_restador_serie_if tile_if();

  tt_um_restador_serie dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .tile_io (tile_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: difference mod 16 and borrow-out from integer arithmetic.
  function automatic logic [3:0] ref_diff(input int a, input int b, input int bi);
    int r;
    r = (a - b - bi + 32) % 16;
    return r[3:0];
  endfunction

  function automatic logic ref_borrow(input int a, input int b, input int bi);
    return (a < (b + bi));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tile_if.ena    = 1'b1;
    tile_if.ui_in  = 8'h00;
    tile_if.uio_in = 8'h00;
    #12;
    total++;
    if (tile_if.uo_out !== 8'h00) begin
      bad++;
      $display("FAIL reset_uo_out got=%h exp=00", tile_if.uo_out);
    end
    total++;
    if ({tile_if.uio_out, tile_if.uio_oe} !== 16'h0000) begin
      bad++;
      $display("FAIL reset_uio got=%h/%h exp=00/00", tile_if.uio_out, tile_if.uio_oe);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    total++;
    if (tile_if.uo_out !== 8'h00) begin
      bad++;
      $display("FAIL idle_after_reset got=%h exp=00", tile_if.uo_out);
    end
  endtask

  // One full operation; toggle=1 scrambles operand pins during SHIFT.
  task automatic run_op(input int a, input int b, input int bi, input bit toggle, input string nm);
    logic [3:0] ed;
    logic       eb;
    int         busy_cnt;
    ed = ref_diff(a, b, bi);
    eb = ref_borrow(a, b, bi);
    busy_cnt = 0;
    tile_if.ui_in  = {b[3:0], a[3:0]};
    tile_if.uio_in = {6'd0, bi[0], 1'b1};
    tick();
    if (tile_if.uo_out[5] === 1'b1) busy_cnt++;
    tile_if.uio_in[0] = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      if (toggle) begin
        tile_if.ui_in     = 8'($urandom);
        tile_if.uio_in[1] = 1'($urandom);
        tile_if.uio_in[7:2] = 6'($urandom);
      end
      tick();
      if (tile_if.uo_out[5] === 1'b1) busy_cnt++;
      total++;
      if (tile_if.uo_out[7] !== ed[k-1]) begin
        bad++;
        $display("FAIL %s serial_bit%0d got=%b exp=%b", nm, k - 1, tile_if.uo_out[7], ed[k-1]);
      end
    end
    total++;
    if (tile_if.uo_out[6:0] !== {1'b1, 1'b0, eb, ed}) begin
      bad++;
      $display("FAIL %s result A=%0d B=%0d bin=%0d got=%b exp=%b", nm, a, b, bi,
               tile_if.uo_out[6:0], {1'b1, 1'b0, eb, ed});
    end
    total++;
    if (busy_cnt !== 4) begin
      bad++;
      $display("FAIL %s busy_cycles got=%0d exp=4", nm, busy_cnt);
    end
    tick();
    total++;
    if (tile_if.uo_out[6:5] !== 2'b00) begin
      bad++;
      $display("FAIL %s back_to_idle busy/done got=%b exp=00", nm, tile_if.uo_out[6:5]);
    end
  endtask

  task automatic test_directed();
    run_op(9, 3, 0, 1'b0, "a9_b3");
    run_op(3, 9, 0, 1'b0, "a3_b9");
    run_op(0, 0, 1, 1'b0, "a0_b0_bin1");
    run_op(15, 15, 0, 1'b0, "a15_b15");
  endtask

  task automatic test_start_held();
    logic [3:0] ed;
    ed = ref_diff(12, 5, 1);
    tile_if.ui_in  = {4'd5, 4'd12};
    tile_if.uio_in = 8'b0000_0011;
    for (int i = 0; i < 20; i++) begin
      tick();
      total++;
      if (tile_if.uo_out[6:5] !== ((i < 4) ? 2'b01 : 2'b10)) begin
        bad++;
        $display("FAIL held_start cycle%0d busy/done got=%b exp=%b", i,
                 tile_if.uo_out[6:5], (i < 4) ? 2'b01 : 2'b10);
      end
    end
    total++;
    if (tile_if.uo_out[4:0] !== {ref_borrow(12, 5, 1), ed}) begin
      bad++;
      $display("FAIL held_start result got=%b exp=%b", tile_if.uo_out[4:0],
               {ref_borrow(12, 5, 1), ed});
    end
    tile_if.uio_in[0] = 1'b0;
    tick();
    total++;
    if (tile_if.uo_out[6:5] !== 2'b00) begin
      bad++;
      $display("FAIL held_start release busy/done got=%b exp=00", tile_if.uo_out[6:5]);
    end
    run_op(10, 4, 1, 1'b0, "after_held");
  endtask

  task automatic test_toggle_inputs();
    run_op(13, 6, 1, 1'b1, "toggle_fixed");
    for (int i = 0; i < 12; i++) begin
      run_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
             int'($urandom_range(0, 1)), 1'($urandom), "random");
    end
  endtask

  task automatic test_reset_mid_op();
    tile_if.ui_in  = {4'd11, 4'd14};
    tile_if.uio_in = 8'b0000_0011;
    tick();
    tile_if.uio_in[0] = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    total++;
    if (tile_if.uo_out !== 8'h00) begin
      bad++;
      $display("FAIL mid_reset uo_out got=%h exp=00", tile_if.uo_out);
    end
    tick();
    rst_n = 1'b1;
    tick();
    total++;
    if (tile_if.uo_out !== 8'h00) begin
      bad++;
      $display("FAIL mid_reset released got=%h exp=00", tile_if.uo_out);
    end
    run_op(7, 2, 1, 1'b0, "after_reset");
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_directed();
    test_start_held();
    test_toggle_inputs();
    test_reset_mid_op();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
